pipe_reg_chain: RTL and testbench



---
 rtl/pipe_pkg.sv | 52 +++++
 rtl/pipe_stage.sv | 75 +++++++
 rtl/pipe_reg_chain.sv | 73 +++++++
 tb/tb_pipe_reg_chain.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Inter-stage bundle types for the 5-stage core and their NOOP reset values.
// Pass one of the NOOP constants as the RESET_DATA value of a pipe_reg_chain instance.
package pipe_pkg;

    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
        logic        valid;
    } if_id_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        valid;
    } id_ex_bundle_t;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] ir;
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic        take_branch;
        logic        valid;
    } ex_mem_bundle_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] alu_res;
        logic [31:0] mem_data;
        logic        valid;
    } mem_wb_bundle_t;

    localparam if_id_bundle_t  IF_ID_NOOP  = '{pc: '0, npc: '0, ir: NOOP_INST, valid: 1'b0};
    localparam id_ex_bundle_t  ID_EX_NOOP  = '{pc: '0, npc: '0, ir: NOOP_INST, rs1_val: '0,
                                              rs2_val: '0, imm: '0, valid: 1'b0};
    localparam ex_mem_bundle_t EX_MEM_NOOP = '{npc: '0, ir: NOOP_INST, alu_res: '0, rs2_val: '0,
                                              take_branch: 1'b0, valid: 1'b0};
    localparam mem_wb_bundle_t MEM_WB_NOOP = '{ir: NOOP_INST, alu_res: '0, mem_data: '0, valid: 1'b0};

    // Occupancy counter width; it must be able to hold 2*DEPTH when the skid registers are built.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register stage: valid bit, payload, local ready logic.
// With PIPE_CHAIN_SKID_EN defined, a skid register per stage makes ready a flop output.
module pipe_stage #(
    parameter int               DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    assign o_valid = r_valid;
    assign o_data  = r_data;

`ifdef PIPE_CHAIN_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_main_free;

    assign o_ready     = !r_skid_valid;
    assign w_main_free = !r_valid || i_ready;

    // Skid drains into main before any new input; it only fills while main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_data       <= RESET_DATA;
            r_skid_valid <= 1'b0;
            r_skid_data  <= RESET_DATA;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_data       <= RESET_DATA;
            r_skid_valid <= 1'b0;
            r_skid_data  <= RESET_DATA;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_valid      <= 1'b1;
                r_data       <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_valid <= i_valid;
                if (i_valid) r_data <= i_data;
            end
        end else if (i_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end
`else
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end
`endif

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register chain with flush gating and occupancy count.
// Define PIPE_CHAIN_SKID_EN to add a skid register per stage (capacity 2*DEPTH, registered ready).
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    localparam int               CNT_W      = occ_width(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    logic              w_valid [DEPTH+1];
    logic              w_ready [DEPTH+1];
    logic [DATA_W-1:0] w_data  [DEPTH+1];
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CNT_W-1:0]  r_occ;

    // Flush blocks both ports so nothing presented in that cycle is counted or consumed.
    assign w_valid[0]     = in_valid && !flush;
    assign w_data[0]      = in_data;
    assign w_ready[DEPTH] = out_ready && !flush;

    assign in_ready  = w_ready[0] && !flush;
    assign out_valid = w_valid[DEPTH] && !flush;
    assign out_data  = w_data[DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(
            .DATA_W     (DATA_W),
            .RESET_DATA (RESET_DATA)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_flush (flush),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_occ <= r_occ - CNT_W'(1);
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: table-driven stream, hand-written corner sequences,
// and a randomized run against a queue-based reference model (DEPTH=3 and DEPTH=2 instances).
module tb_pipe_reg_chain;

    localparam int         DW = 8;
    localparam logic [7:0] RD = 8'hEE;
`ifdef PIPE_CHAIN_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int CAP3 = SKID ? 6 : 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          fl3, iv3, ir3, ov3, or3;
    logic [DW-1:0] id3, od3;
    logic [2:0]    oc3;
    logic          fl2, iv2, ir2, ov2, or2;
    logic [DW-1:0] id2, od2;
    logic [2:0]    oc2;

    pipe_reg_chain #(.DATA_W(DW), .DEPTH(3), .RESET_DATA(RD)) u3 (
        .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(oc3)
    );

    pipe_reg_chain #(.DATA_W(DW), .DEPTH(2), .RESET_DATA(RD)) u2 (
        .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(oc2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       chk_d;
        logic [7:0] e_od;
        logic [2:0] e_occ;
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        int unsigned t;
    } ent_t;

    vec_t        tbl[10];
    ent_t        q[$];
    int unsigned cyc;
    int          acc, nout, lat;
    logic        fired, e_ir, e_ov, f_in, f_out;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 3'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd2};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 3'd3};
        tbl[4] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3};
        tbl[5] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 3'd3};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 3'd3};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 3'd2};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 3'd1};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

        rst = 1'b1;
        {fl3, iv3, or3, fl2, iv2, or2} = '0;
        id3 = '0; id2 = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready3", ir3, 1);
        chk("rst_out_valid3", ov3, 0);
        chk("rst_out_data3", od3, RD);
        chk("rst_occ3", oc3, 0);
        chk("rst_in_ready2", ir2, 1);
        chk("rst_out_data2", od2, RD);
        @(negedge clk);

        // stream 0x11..0x66 back-to-back into DEPTH=3, including in+out at full occupancy
        for (int i = 0; i < 10; i++) begin
            iv3 = tbl[i].iv; id3 = tbl[i].d; or3 = tbl[i].ordy;
            #1;
            chk("stream_in_ready", ir3, tbl[i].e_ir);
            chk("stream_out_valid", ov3, tbl[i].e_ov);
            chk("stream_occ", oc3, tbl[i].e_occ);
            if (tbl[i].chk_d) chk("stream_out_data", od3, tbl[i].e_od);
            @(negedge clk);
        end

        // backpressure on DEPTH=2 with out_ready=0
        acc = 0;
        or2 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            iv2 = (acc < 4); id2 = 8'hA0 + 8'(acc);
            #1;
            if (ov2) chk("bp_head_stable", od2, 8'hA0);
            if (iv2 && ir2) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, SKID ? 4 : 2);
        iv2 = (acc < 4); id2 = 8'hA0 + 8'(acc);
        #1;
        chk("bp_in_ready", ir2, 0);
        chk("bp_occ", oc2, SKID ? 4 : 2);
        chk("bp_out_data", od2, 8'hA0);
        @(negedge clk);
        or2 = 1'b1; nout = 0;
        for (int c = 0; c < 14; c++) begin
            iv2 = (acc < 4); id2 = 8'hA0 + 8'(acc);
            #1;
            if (ov2) begin
                chk("bp_order", od2, 8'hA0 + 8'(nout));
                nout++;
            end
            if (iv2 && ir2) acc++;
            @(negedge clk);
        end
        chk("bp_drained", nout, 4);
        iv2 = 1'b0;

        // bubble collapse: single entry stalled at head of DEPTH=3
        or3 = 1'b0; iv3 = 1'b1; id3 = 8'hB0;
        #1;
        chk("bub_accept0", ir3, 1);
        @(negedge clk);
        iv3 = 1'b0; lat = 0;
        while (!ov3 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("bub_head_valid", ov3, 1);
        iv3 = 1'b1; id3 = 8'hB1;
        #1;
        chk("bub_accept1", ir3, 1);
        @(negedge clk);
        id3 = 8'hB2;
        #1;
        chk("bub_accept2", ir3, 1);
        @(negedge clk);
        iv3 = 1'b0;
        #1;
        chk("bub_occ", oc3, 3);
        chk("bub_head_data", od3, 8'hB0);
        chk("bub_full_ready", ir3, SKID ? 1 : 0);
        @(negedge clk);

        // flush with full chain and a concurrent input offer
        fl3 = 1'b1; iv3 = 1'b1; id3 = 8'hC0; or3 = 1'b1;
        #1;
        chk("flush_in_ready", ir3, 0);
        chk("flush_out_valid", ov3, 0);
        @(negedge clk);
        fl3 = 1'b0; iv3 = 1'b0;
        #1;
        chk("flush_occ", oc3, 0);
        chk("flush_out_data", od3, RD);
        for (int c = 0; c < 4; c++) begin
            chk("flush_no_output", ov3, 0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);

        // asynchronous reset for half a cycle mid-stream
        iv3 = 1'b1; id3 = 8'hE0; or3 = 1'b1;
        @(negedge clk);
        id3 = 8'hE1;
        @(negedge clk);
        iv3 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", ov3, 0);
        chk("arst_occ", oc3, 0);
        chk("arst_out_data", od3, RD);
        #4 rst = 1'b0;
        @(negedge clk);
        iv3 = 1'b1; id3 = 8'hF0;
        #1;
        chk("arst_accept", ir3, 1);
        @(negedge clk);
        iv3 = 1'b0; lat = 1;
        #1;
        while (!ov3 && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("arst_latency", lat, 3);
        chk("arst_data", od3, 8'hF0);
        @(negedge clk);

        // randomized run on DEPTH=3 against a FIFO + acceptance-time model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        cyc = 0; fired = 1'b0; iv3 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!iv3 || fired) begin
                iv3 = ($urandom_range(0, 3) != 0);
                id3 = 8'($urandom);
            end
            or3 = ($urandom_range(0, 3) != 0);
            fl3 = ($urandom_range(0, 49) == 0);
            #1;
            e_ir = !fl3 && !(q.size() >= CAP3 && !or3);
            e_ov = !fl3 && (q.size() != 0) && ((cyc - q[0].t) >= 2);
            chk("rnd_out_valid", ov3, e_ov);
            chk("rnd_occ", oc3, q.size());
            if (e_ov) chk("rnd_out_data", od3, q[0].d);
`ifdef PIPE_CHAIN_SKID_EN
            if (ir3) chk("rnd_ready_cap", (q.size() < CAP3) && !fl3, 1);
            f_in = iv3 && ir3;
`else
            chk("rnd_in_ready", ir3, e_ir);
            f_in = iv3 && e_ir;
`endif
            f_out = e_ov && or3;
            @(posedge clk);
            cyc++;
            if (fl3) begin
                q.delete();
            end else begin
                if (f_out) void'(q.pop_front());
                if (f_in) q.push_back('{id3, cyc});
            end
            fired = f_in;
            @(negedge clk);
        end
        fl3 = 1'b0; iv3 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
